// File: rtl/tx_swizzler_pkg.sv
// Shared TX-side constants, flusher control markers and lane popcount helper.
// Optional build macro used by tx_swizzler: TX_SWIZZLER_DROP_ERR_EN.
`ifndef TX_PACK_DEFS_SVH
`define TX_PACK_DEFS_SVH
`define ESC_PACK   8'hE5
`define FLUSH_PACK 8'hF1
`endif

package tx_swizzler_pkg;
  localparam int NUM_LANES        = 4;
  localparam int CHUNK_W          = 64;
  localparam int CHUNKS_PER_FRAME = 3;
  localparam int BUF_DEPTH        = 8;

  localparam int FRAME_W    = CHUNKS_PER_FRAME * CHUNK_W;
  localparam int PTR_W      = $clog2(BUF_DEPTH);
  localparam int CNT_W      = $clog2(BUF_DEPTH + 1);
  localparam int LANE_IDX_W = $clog2(NUM_LANES);
  localparam int K_W        = $clog2(NUM_LANES + 1);

  typedef logic [CHUNK_W-1:0] chunk_t;

  function automatic logic [K_W-1:0] lane_popcount(input logic [NUM_LANES-1:0] mask);
    logic [K_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n = n + K_W'(mask[i]);
    end
    return n;
  endfunction
endpackage

// File: rtl/tx_swizzler_lane_mapper.sv
// Combinational lane mapper: number of available lanes and, per lane, which
// chunk (offset from the read pointer) it receives when a pop happens.
module tx_lane_mapper
  import tx_swizzler_pkg::*;
(
  input  logic [NUM_LANES-1:0]                 i_lane_avail,
  output logic [K_W-1:0]                       o_k,
  output logic [NUM_LANES-1:0][LANE_IDX_W-1:0] o_offset
);
  assign o_k = lane_popcount(i_lane_avail);

  // A lane's offset is the number of available lanes below it.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_offset
    assign o_offset[gi] = LANE_IDX_W'(lane_popcount(i_lane_avail & NUM_LANES'((1 << gi) - 1)));
  end
endmodule

// File: rtl/tx_swizzler.sv
// Splits 192-bit flusher frames into 64-bit chunks and deals them round-robin
// onto available PCS lanes. Define TX_SWIZZLER_DROP_ERR_EN to add out_drop_err.
module tx_swizzler
  import tx_swizzler_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_enable,
  input  logic [FRAME_W-1:0]             in_txdata,
  input  logic                           in_txdata_valid,
  output logic                           out_idle,
  input  logic [NUM_LANES-1:0]           in_lane_avail,
  output logic [NUM_LANES*CHUNK_W-1:0]   out_lane_data,
  output logic [NUM_LANES-1:0]           out_lane_valid
`ifdef TX_SWIZZLER_DROP_ERR_EN
  ,
  output logic                           out_drop_err
`endif
);
  chunk_t                              r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]                    r_rd_ptr;
  logic [PTR_W-1:0]                    r_wr_ptr;
  logic [CNT_W-1:0]                    r_count;
  logic [NUM_LANES-1:0]                r_lane_valid;

  logic [K_W-1:0]                      w_k;
  logic [NUM_LANES-1:0][LANE_IDX_W-1:0] w_offset;
  logic                                w_push;
  logic                                w_pop;
  logic [CNT_W-1:0]                    w_count_next;

  tx_lane_mapper u_mapper (
    .i_lane_avail (in_lane_avail),
    .o_k          (w_k),
    .o_offset     (w_offset)
  );

  // Room for a whole frame is required before accepting one.
  assign out_idle = in_enable && reset_n &&
                    (r_count <= CNT_W'(BUF_DEPTH - CHUNKS_PER_FRAME));
  assign w_push   = in_txdata_valid && out_idle;
  // Only pop when every available lane can be filled from chunks already held.
  assign w_pop    = in_enable && (w_k != '0) && (r_count >= CNT_W'(w_k));

  assign w_count_next = r_count
                      + (w_push ? CNT_W'(CHUNKS_PER_FRAME) : '0)
                      - (w_pop  ? CNT_W'(w_k)              : '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int i = 0; i < CHUNKS_PER_FRAME; i++) begin
        r_buf[r_wr_ptr + PTR_W'(i)] <= in_txdata[i*CHUNK_W +: CHUNK_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_lane_valid <= '0;
    end else begin
      r_count      <= w_count_next;
      r_lane_valid <= w_pop ? in_lane_avail : '0;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(CHUNKS_PER_FRAME);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(w_k);
    end
  end

  assign out_lane_valid = r_lane_valid;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [PTR_W-1:0] w_rd_idx;
    chunk_t           r_data;

    assign w_rd_idx = r_rd_ptr + PTR_W'(w_offset[gi]);

    // Unpopped lanes keep their last chunk.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_data <= '0;
      end else if (w_pop && in_lane_avail[gi]) begin
        r_data <= r_buf[w_rd_idx];
      end
    end

    assign out_lane_data[gi*CHUNK_W +: CHUNK_W] = r_data;
  end

`ifdef TX_SWIZZLER_DROP_ERR_EN
  logic w_drop;
  logic r_drop_err;

  assign w_drop = in_enable && reset_n && in_txdata_valid && !out_idle;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_drop_err <= 1'b0;
    end else if (w_drop) begin
      r_drop_err <= 1'b1;
    end
  end

  assign out_drop_err = r_drop_err;

`ifdef PCS_SIM
  always_ff @(posedge clk) begin
    assert (!w_drop) else $fatal(1, "tx_swizzler: frame offered while not idle");
  end
`endif
`endif
endmodule

// File: tb/tb_tx_swizzler.sv
// Scoreboard bench for tx_swizzler: a chunk-queue model predicts each cycle's
// lane outputs, which are compared once the DUT registers them.
module tb_tx_swizzler;
  import tx_swizzler_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_enable;
  logic [191:0] in_txdata;
  logic         in_txdata_valid;
  logic [3:0]   in_lane_avail;
  wire          out_idle;
  wire  [255:0] out_lane_data;
  wire  [3:0]   out_lane_valid;
`ifdef TX_SWIZZLER_DROP_ERR_EN
  wire          out_drop_err;
`endif

  always #5 clk = ~clk;

  tx_swizzler dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_enable       (in_enable),
    .in_txdata       (in_txdata),
    .in_txdata_valid (in_txdata_valid),
    .out_idle        (out_idle),
    .in_lane_avail   (in_lane_avail),
    .out_lane_data   (out_lane_data),
    .out_lane_valid  (out_lane_valid)
`ifdef TX_SWIZZLER_DROP_ERR_EN
    ,
    .out_drop_err    (out_drop_err)
`endif
  );

  typedef struct packed {
    logic [3:0]   v;
    logic [255:0] d;
  } exp_t;

  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_cyc    = 0;
  logic [63:0]  mq[$];
  logic [3:0]   m_v = '0;
  logic [255:0] m_d = '0;
  exp_t         exp_q[$];

  function automatic logic [191:0] frame(input int f);
    logic [191:0] r;
    for (int c = 0; c < 3; c++) begin
      r[64*c +: 64] = 64'hA500_0000_0000_0000 | (64'(f) << 8) | 64'(c);
    end
    return r;
  endfunction

  function automatic bit model_idle();
    return in_enable && reset_n && (mq.size() <= 5);
  endfunction

  task automatic drive(input bit v, input logic [191:0] d, input logic [3:0] m,
                       input bit en, input bit rn);
    in_txdata_valid = v;
    in_txdata       = d;
    in_lane_avail   = m;
    in_enable       = en;
    reset_n         = rn;
    #1;
  endtask

  // Advances one clock; the model's prediction for that edge goes on exp_q.
  task automatic cycle(output bit acc);
    int   k;
    exp_t e;
    acc = 1'b0;
    if (!reset_n) begin
      mq.delete();
      m_v = '0;
      m_d = '0;
    end else if (!in_enable) begin
      m_v = '0;
    end else begin
      acc = in_txdata_valid && model_idle();
      k   = $countones(in_lane_avail);
      m_v = '0;
      if (k > 0 && mq.size() >= k) begin
        for (int i = 0; i < 4; i++) begin
          if (in_lane_avail[i]) begin
            m_d[64*i +: 64] = mq.pop_front();
            m_v[i] = 1'b1;
          end
        end
      end
      if (acc) begin
        for (int c = 0; c < 3; c++) mq.push_back(in_txdata[64*c +: 64]);
      end
    end
    e.v = m_v;
    e.d = m_d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic apply_reset();
    bit acc;
    drive(1'b0, '0, 4'h0, 1'b1, 1'b0);
    cycle(acc);
    exp_q.delete();
  endtask

  task automatic test_reset();
    bit   acc;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, frame(99), 4'hF, 1'b1, 1'b0);
      n_checks++;
      if (out_idle !== 1'b0) $display("FAIL reset_idle got %b exp 0", out_idle);
      else n_pass++;
      cycle(acc);
      e = exp_q.pop_front();
      n_checks++;
      if (out_lane_valid !== e.v) $display("FAIL reset_valid got %h exp %h", out_lane_valid, e.v);
      else n_pass++;
      n_checks++;
      if (out_lane_data !== e.d) $display("FAIL reset_data got %h exp %h", out_lane_data, e.d);
      else n_pass++;
    end
  endtask

  task automatic test_full_stream();
    bit   acc;
    bit   v;
    exp_t e;
    int   f = 0, low_run = 0, max_low = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      v = (f < 4) && (mq.size() <= 5);
      drive(v, frame(f), 4'hF, 1'b1, 1'b1);
      n_checks++;
      if (out_idle !== model_idle()) $display("FAIL full_idle cyc %0d got %b exp %b", n_cyc, out_idle, model_idle());
      else n_pass++;
      low_run = out_idle ? 0 : low_run + 1;
      if (low_run > max_low) max_low = low_run;
      cycle(acc);
      if (acc) f++;
      e = exp_q.pop_front();
      n_checks++;
      if (out_lane_valid !== e.v) $display("FAIL full_valid cyc %0d got %h exp %h", n_cyc, out_lane_valid, e.v);
      else n_pass++;
      n_checks++;
      if (out_lane_data !== e.d) $display("FAIL full_data cyc %0d got %h exp %h", n_cyc, out_lane_data, e.d);
      else n_pass++;
    end
    n_checks++;
    if (max_low >= 2) $display("FAIL full_idle_run got %0d exp <2", max_low);
    else n_pass++;
  endtask

  task automatic test_partial();
    bit   acc;
    exp_t e;
    bit   tv[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    int   f = 10;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tv[i], frame(f), 4'b1010, 1'b1, 1'b1);
      n_checks++;
      if (out_idle !== model_idle()) $display("FAIL partial_idle cyc %0d got %b exp %b", n_cyc, out_idle, model_idle());
      else n_pass++;
      cycle(acc);
      if (acc) f++;
      e = exp_q.pop_front();
      n_checks++;
      if (out_lane_valid !== e.v) $display("FAIL partial_valid cyc %0d got %h exp %h", n_cyc, out_lane_valid, e.v);
      else n_pass++;
      n_checks++;
      if (out_lane_data !== e.d) $display("FAIL partial_data cyc %0d got %h exp %h", n_cyc, out_lane_data, e.d);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    bit           acc;
    exp_t         e;
    bit           tv[6] = '{1, 0, 0, 1, 0, 0};
    logic [191:0] fr;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      fr = (i < 3) ? frame(20) : {64'hF1F1_0000_0000_0002, 64'hF1F1_0000_0000_0001, 64'hF1F1_0000_0000_00F1};
      drive(tv[i], fr, 4'hF, 1'b1, 1'b1);
      n_checks++;
      if (out_idle !== model_idle()) $display("FAIL flush_idle cyc %0d got %b exp %b", n_cyc, out_idle, model_idle());
      else n_pass++;
      cycle(acc);
      e = exp_q.pop_front();
      n_checks++;
      if (out_lane_valid !== e.v) $display("FAIL flush_valid cyc %0d got %h exp %h", n_cyc, out_lane_valid, e.v);
      else n_pass++;
      n_checks++;
      if (out_lane_data !== e.d) $display("FAIL flush_data cyc %0d got %h exp %h", n_cyc, out_lane_data, e.d);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit   acc;
    exp_t e;
    int   n_acc = 0;
    int   f = 30;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(i < 5, frame(f), (i < 5) ? 4'h0 : 4'hF, 1'b1, 1'b1);
      n_checks++;
      if (out_idle !== model_idle()) $display("FAIL bp_idle cyc %0d got %b exp %b", n_cyc, out_idle, model_idle());
      else n_pass++;
      if (in_txdata_valid && out_idle) n_acc++;
      cycle(acc);
      if (acc) f++;
      e = exp_q.pop_front();
      n_checks++;
      if (out_lane_valid !== e.v) $display("FAIL bp_valid cyc %0d got %h exp %h", n_cyc, out_lane_valid, e.v);
      else n_pass++;
      n_checks++;
      if (out_lane_data !== e.d) $display("FAIL bp_data cyc %0d got %h exp %h", n_cyc, out_lane_data, e.d);
      else n_pass++;
    end
    n_checks++;
    if (n_acc !== 2) $display("FAIL bp_accepted got %0d exp 2", n_acc);
    else n_pass++;
  endtask

  task automatic test_enable_reset();
    bit         acc;
    exp_t       e;
    int         f = 40;
    bit         tv[10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [3:0] tm[10] = '{4'h0, 4'h0, 4'h1, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF};
    bit         te[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    bit         tr[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tv[i], frame(f), tm[i], te[i], tr[i]);
      n_checks++;
      if (out_idle !== model_idle()) $display("FAIL en_idle cyc %0d got %b exp %b", n_cyc, out_idle, model_idle());
      else n_pass++;
      cycle(acc);
      if (acc) f++;
      e = exp_q.pop_front();
      n_checks++;
      if (out_lane_valid !== e.v) $display("FAIL en_valid cyc %0d got %h exp %h", n_cyc, out_lane_valid, e.v);
      else n_pass++;
      n_checks++;
      if (out_lane_data !== e.d) $display("FAIL en_data cyc %0d got %h exp %h", n_cyc, out_lane_data, e.d);
      else n_pass++;
    end
  endtask

`ifdef TX_SWIZZLER_DROP_ERR_EN
  task automatic test_drop();
    bit         acc;
    exp_t       e;
    int         f = 50;
    bit         tv[7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [3:0] tm[7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
    logic       td[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(tv[i], frame(f), tm[i], 1'b1, 1'b1);
      cycle(acc);
      if (acc) f++;
      e = exp_q.pop_front();
      n_checks++;
      if (out_drop_err !== td[i]) $display("FAIL drop_err cyc %0d got %b exp %b", n_cyc, out_drop_err, td[i]);
      else n_pass++;
      n_checks++;
      if (out_lane_data !== e.d || out_lane_valid !== e.v)
        $display("FAIL drop_lanes cyc %0d got %h/%h exp %h/%h", n_cyc, out_lane_valid, out_lane_data, e.v, e.d);
      else n_pass++;
    end
    apply_reset();
    n_checks++;
    if (out_drop_err !== 1'b0) $display("FAIL drop_err_reset got %b exp 0", out_drop_err);
    else n_pass++;
  endtask
`endif

  initial begin
    drive(1'b0, '0, 4'hF, 1'b1, 1'b0);
    test_reset();
    test_full_stream();
    test_partial();
    test_flush();
    test_backpressure();
    test_enable_reset();
`ifdef TX_SWIZZLER_DROP_ERR_EN
    test_drop();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
